// File: rtl/mux_8x1_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encoding and requester count.
package mux_arb_defs;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   localparam int ARB_N = 8;

endpackage

// File: rtl/mux_8x1_rr_arbiter_if.sv
// Requester/consumer bundle shared by the arbiter and its environment.
interface mux_8x1_rr_arbiter_if
   import mux_arb_defs::*;
#(
   parameter int width = 8
);
   logic [ARB_N-1:0] req;
   logic [width-1:0] i0, i1, i2, i3, i4, i5, i6, i7;
   logic             ready;
   logic [ARB_N-1:0] gnt;
   logic [2:0]       select;
   logic             en;
   logic             valid;

   modport master (
      output req, i0, i1, i2, i3, i4, i5, i6, i7, ready,
      input  gnt, select, en, valid
   );

   modport slave (
      input  req, i0, i1, i2, i3, i4, i5, i6, i7, ready,
      output gnt, select, en, valid
   );
endinterface

// File: rtl/mux_8x1_rr_arbiter_mux.sv
// Existing 8:1 datapath mux; output floats whenever the enable is low.
module mux_8x1 #(
   parameter int width = 8
) (
   input  logic [width-1:0] i_0,
   input  logic [width-1:0] i_1,
   input  logic [width-1:0] i_2,
   input  logic [width-1:0] i_3,
   input  logic [width-1:0] i_4,
   input  logic [width-1:0] i_5,
   input  logic [width-1:0] i_6,
   input  logic [width-1:0] i_7,
   input  logic [2:0]       i_select,
   input  logic             i_en,
   output logic [width-1:0] o_out
);
   logic [width-1:0] w_data;

   always_comb begin
      w_data = i_0;
      case (i_select)
         3'd0: w_data = i_0;
         3'd1: w_data = i_1;
         3'd2: w_data = i_2;
         3'd3: w_data = i_3;
         3'd4: w_data = i_4;
         3'd5: w_data = i_5;
         3'd6: w_data = i_6;
         3'd7: w_data = i_7;
         default: w_data = i_0;
      endcase
   end

   assign o_out = i_en ? w_data : 'z;
endmodule

// File: rtl/mux_8x1_rr_arbiter.sv
// Round-robin arbiter owning the select/enable of a shared 8:1 mux; bursts of up to
// max_beats valid/ready transfers per grant.
//
// state     | meaning
// ARB_IDLE  | no grant; pick next requester after ptr
// ARB_GRANT | path owned by select; count beats until limit or req drop
module mux_8x1_rr_arbiter
   import mux_arb_defs::*;
#(
   parameter int width     = 8,
   parameter int max_beats = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   mux_8x1_rr_arbiter_if.slave   bus,
   output logic [width-1:0]      out
);
   localparam int CW = (max_beats > 1) ? $clog2(max_beats) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(max_beats - 1);

   arb_state_e       r_state, w_state_nxt;
   logic [ARB_N-1:0] r_gnt, w_gnt_nxt;
   logic [2:0]       r_select, w_select_nxt;
   logic             r_en, w_en_nxt;
   logic [CW-1:0]    r_beat_cnt, w_beat_cnt_nxt;
   logic [2:0]       r_ptr, w_ptr_nxt;
   logic [2:0]       w_winner;
   logic             w_valid;
   logic             w_xfer;

   // First set request scanning upward from ptr+1; k = ARB_N wraps back to ptr itself.
   function automatic logic [2:0] rr_pick(input logic [ARB_N-1:0] req_v, input logic [2:0] ptr_v);
      logic [2:0] idx;
      rr_pick = ptr_v;
      for (int k = ARB_N; k >= 1; k--) begin
         idx = ptr_v + 3'(k);
         if (req_v[idx]) rr_pick = idx;
      end
   endfunction

   assign w_winner = rr_pick(bus.req, r_ptr);
   assign w_valid  = r_en & bus.req[r_select];
   assign w_xfer   = w_valid & bus.ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ARB_IDLE;
         r_gnt      <= '0;
         r_select   <= '0;
         r_en       <= 1'b0;
         r_beat_cnt <= '0;
         r_ptr      <= 3'd7;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt      <= w_gnt_nxt;
         r_select   <= w_select_nxt;
         r_en       <= w_en_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_ptr      <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_gnt_nxt      = r_gnt;
      w_select_nxt   = r_select;
      w_en_nxt       = r_en;
      w_beat_cnt_nxt = r_beat_cnt;
      w_ptr_nxt      = r_ptr;
      case (r_state)
         ARB_IDLE: begin
            if (|bus.req) begin
               w_state_nxt    = ARB_GRANT;
               w_gnt_nxt      = 8'b1 << w_winner;
               w_select_nxt   = w_winner;
               w_en_nxt       = 1'b1;
               w_beat_cnt_nxt = '0;
            end
         end
         ARB_GRANT: begin
            // A dropped request releases without a beat since valid is low that cycle.
            if (!bus.req[r_select] || (w_xfer && r_beat_cnt == LAST_BEAT)) begin
               w_state_nxt    = ARB_IDLE;
               w_gnt_nxt      = '0;
               w_en_nxt       = 1'b0;
               w_beat_cnt_nxt = '0;
               w_ptr_nxt      = r_select;
            end else if (w_xfer) begin
               w_beat_cnt_nxt = r_beat_cnt + CW'(1);
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   assign bus.gnt    = r_gnt;
   assign bus.select = r_select;
   assign bus.en     = r_en;
   assign bus.valid  = w_valid;

   mux_8x1 #(
      .width (width)
   ) u_mux (
      .i_0      (bus.i0),
      .i_1      (bus.i1),
      .i_2      (bus.i2),
      .i_3      (bus.i3),
      .i_4      (bus.i4),
      .i_5      (bus.i5),
      .i_6      (bus.i6),
      .i_7      (bus.i7),
      .i_select (r_select),
      .i_en     (r_en),
      .o_out    (out)
   );
endmodule

// File: tb/tb_mux_8x1_rr_arbiter.sv
// Directed bench for the round-robin mux arbiter with beat and grant scoreboards.
module tb_mux_8x1_rr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic [7:0] q_beat1[$];
   logic [7:0] q_gnt1[$];
   logic [7:0] q_beat2[$];
   logic [7:0] q_gnt2[$];
   logic       prev_en1 = 1'b0;
   logic       prev_en2 = 1'b0;

   wire [7:0] out1;
   wire [7:0] out2;

   mux_8x1_rr_arbiter_if #(.width(8)) bus1 ();
   mux_8x1_rr_arbiter_if #(.width(8)) bus2 ();

   mux_8x1_rr_arbiter #(.width(8), .max_beats(4)) dut1 (
      .clk (clk), .rst (rst), .bus (bus1.slave), .out (out1)
   );
   mux_8x1_rr_arbiter #(.width(8), .max_beats(1)) dut2 (
      .clk (clk), .rst (rst), .bus (bus2.slave), .out (out2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beats1(input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) q_beat1.push_back(d);
   endtask

   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst && bus1.valid && bus1.ready) begin
         chk("beat1_expected", 32'(q_beat1.size() != 0), 1);
         if (q_beat1.size() != 0) begin
            e = q_beat1.pop_front();
            chk("beat1_data", 32'(out1), 32'(e));
         end
      end
      if (bus1.en && !prev_en1) begin
         chk("grant1_expected", 32'(q_gnt1.size() != 0), 1);
         if (q_gnt1.size() != 0) begin
            e = q_gnt1.pop_front();
            chk("grant1_select", 32'(bus1.select), 32'(e));
            chk("grant1_onehot", 32'(bus1.gnt), 32'(8'b1 << e[2:0]));
         end
      end
      prev_en1 = bus1.en;
      if (!rst && bus2.valid && bus2.ready) begin
         chk("beat2_expected", 32'(q_beat2.size() != 0), 1);
         if (q_beat2.size() != 0) begin
            e = q_beat2.pop_front();
            chk("beat2_data", 32'(out2), 32'(e));
         end
      end
      if (bus2.en && !prev_en2) begin
         chk("grant2_expected", 32'(q_gnt2.size() != 0), 1);
         if (q_gnt2.size() != 0) begin
            e = q_gnt2.pop_front();
            chk("grant2_select", 32'(bus2.select), 32'(e));
         end
      end
      prev_en2 = bus2.en;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus1.req = '0; bus1.ready = 1'b0;
      bus2.req = '0; bus2.ready = 1'b0;
      bus1.i0 = 8'hA0; bus1.i1 = 8'hA1; bus1.i2 = 8'hA2; bus1.i3 = 8'hA3;
      bus1.i4 = 8'hA4; bus1.i5 = 8'hA5; bus1.i6 = 8'hA6; bus1.i7 = 8'hA7;
      bus2.i0 = 8'hC0; bus2.i1 = 8'hC1; bus2.i2 = 8'hC2; bus2.i3 = 8'hC3;
      bus2.i4 = 8'hC4; bus2.i5 = 8'hC5; bus2.i6 = 8'hC6; bus2.i7 = 8'hC7;
      rst = 1'b1;
      step();
      step();
      chk("rst_gnt", 32'(bus1.gnt), 0);
      chk("rst_en", 32'(bus1.en), 0);
      chk("rst_select", 32'(bus1.select), 0);
      chk("rst_valid", 32'(bus1.valid), 0);
      chk("rst_ptr", 32'(dut1.r_ptr), 7);

      // single requester, four-beat burst
      rst = 1'b0; bus1.ready = 1'b1; bus1.req = 8'b0000_0001;
      q_gnt1.push_back(8'd0); push_beats1(8'hA0, 4);
      step();
      chk("t1_gnt", 32'(bus1.gnt), 32'h01);
      step(); step(); step();
      chk("t1_beat_cnt", 32'(dut1.r_beat_cnt), 3);
      step();
      chk("t1_release_gnt", 32'(bus1.gnt), 0);
      chk("t1_release_en", 32'(bus1.en), 0);
      bus1.req = '0;

      // all requesting: rotation 0..7,0 with one idle cycle between grants
      rst = 1'b1;
      step();
      rst = 1'b0; bus1.req = 8'hFF;
      for (int g = 0; g < 9; g++) begin
         q_gnt1.push_back(8'(g % 8));
         push_beats1(8'hA0 + 8'(g % 8), 4);
      end
      for (int g = 0; g < 9; g++) begin
         step();
         chk("t2_rot_gnt", 32'(bus1.gnt), 32'(8'b1 << (g % 8)));
         step(); step(); step(); step();
         chk("t2_gap_en", 32'(bus1.en), 0);
      end
      bus1.req = '0;

      // requester 3 stalled by ready low
      bus1.req = 8'b0000_1000;
      q_gnt1.push_back(8'd3); push_beats1(8'hA3, 4);
      step();
      chk("t3_gnt", 32'(bus1.gnt), 32'h08);
      step();
      bus1.ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_hold_gnt", 32'(bus1.gnt), 32'h08);
         chk("t3_hold_select", 32'(bus1.select), 3);
         chk("t3_hold_cnt", 32'(dut1.r_beat_cnt), 1);
      end
      bus1.ready = 1'b1;
      step(); step(); step();
      chk("t3_release_en", 32'(bus1.en), 0);
      bus1.req = '0;

      // requester 5 drops request mid-burst
      bus1.req = 8'b0010_0000;
      q_gnt1.push_back(8'd5); push_beats1(8'hA5, 2);
      step();
      chk("t4_gnt", 32'(bus1.gnt), 32'h20);
      step(); step();
      bus1.req = '0;
      #1;
      chk("t4_drop_valid", 32'(bus1.valid), 0);
      step();
      chk("t4_release_en", 32'(bus1.en), 0);
      chk("t4_ptr", 32'(dut1.r_ptr), 5);
      bus1.req = 8'b0010_0001;
      q_gnt1.push_back(8'd0); push_beats1(8'hA0, 4);
      step();
      chk("t4_next_gnt", 32'(bus1.gnt), 32'h01);
      step(); step(); step(); step();
      bus1.req = '0;
      chk("t4_done_en", 32'(bus1.en), 0);

      // reset during the third beat of a burst
      bus1.req = 8'b0000_0100;
      q_gnt1.push_back(8'd2); push_beats1(8'hA2, 2);
      step();
      chk("t5_gnt", 32'(bus1.gnt), 32'h04);
      step(); step();
      rst = 1'b1;
      step();
      chk("t5_rst_gnt", 32'(bus1.gnt), 0);
      chk("t5_rst_en", 32'(bus1.en), 0);
      chk("t5_rst_valid", 32'(bus1.valid), 0);
      chk("t5_rst_select", 32'(bus1.select), 0);
      chk("t5_rst_ptr", 32'(dut1.r_ptr), 7);
      chk("t5_rst_cnt", 32'(dut1.r_beat_cnt), 0);
      rst = 1'b0; bus1.req = 8'b0000_0101;
      q_gnt1.push_back(8'd0); push_beats1(8'hA0, 4);
      step();
      chk("t5_next_gnt", 32'(bus1.gnt), 32'h01);
      step(); step(); step(); step();
      bus1.req = '0;
      chk("t5_done_en", 32'(bus1.en), 0);

      // single-beat grants alternate between 0 and 7
      bus2.ready = 1'b1; bus2.req = 8'b1000_0001;
      for (int j = 0; j < 4; j++) begin
         q_gnt2.push_back((j % 2 == 0) ? 8'd0 : 8'd7);
         q_beat2.push_back((j % 2 == 0) ? 8'hC0 : 8'hC7);
      end
      for (int j = 0; j < 4; j++) begin
         step();
         chk("t6_gnt", 32'(bus2.gnt), (j % 2 == 0) ? 32'h01 : 32'h80);
         step();
         chk("t6_gap_en", 32'(bus2.en), 0);
      end
      bus2.req = '0;

      step(); step();
      chk("q_beat1_empty", 32'(q_beat1.size()), 0);
      chk("q_gnt1_empty", 32'(q_gnt1.size()), 0);
      chk("q_beat2_empty", 32'(q_beat2.size()), 0);
      chk("q_gnt2_empty", 32'(q_gnt2.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
